// File: rtl/rr_hold_arbiter.sv
// N-way round-robin bus arbiter with a high-priority request class and bounded hold locking.
// The granted requester may keep the bus with hold for at most MAX_HOLD consecutive cycles.
module rr_hold_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16,
  localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              plusclk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  req_type,
  input  logic [N_REQ-1:0]  hold,
  output logic [N_REQ-1:0]  grant,
  output logic [ID_W-1:0]   grant_id,
  output logic              grant_valid,
  output logic              grant_hp,
  output logic              hold_timeout
);

  localparam int HCNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOCK
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic                hp_q, hp_d;
  logic                to_q, to_d;

  logic [N_REQ-1:0]    hp_reqs;
  logic                hp_pending;
  logic [N_REQ-1:0]    cand;
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic                locked_req;
  logic                cont;
  logic                timeout;

  // Rotating priority scan starting at ptr; the previous winner sits last.
  always_comb begin
    hp_reqs    = req & req_type;
    hp_pending = |hp_reqs;
    cand       = hp_pending ? hp_reqs : req;
    win_found  = 1'b0;
    win_id     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && cand[(int'(ptr_q) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    locked_req = (state_q != IDLE) && req[gid_q] && hold[gid_q];
    cont       = locked_req && (hcnt_q < HCNT_W'(MAX_HOLD));
    timeout    = locked_req && (hcnt_q == HCNT_W'(MAX_HOLD));
  end

  always_ff @(posedge plusclk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hcnt_q  <= '0;
      gid_q   <= '0;
      hp_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      gid_q   <= gid_d;
      hp_q    <= hp_d;
      to_q    <= to_d;
    end
  end

  // A continuing holder is never preempted; otherwise a fresh winner is picked in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    gid_d   = gid_q;
    hp_d    = hp_q;
    to_d    = 1'b0;
    if (cont) begin
      state_d = LOCK;
      hcnt_d  = hcnt_q + HCNT_W'(1);
    end else if (win_found) begin
      state_d = GRANT;
      gid_d   = win_id;
      ptr_d   = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
      hcnt_d  = HCNT_W'(1);
      hp_d    = hp_pending;
      to_d    = timeout;
    end else begin
      state_d = IDLE;
      gid_d   = '0;
      hcnt_d  = '0;
      hp_d    = 1'b0;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q != IDLE) begin
      grant[gid_q] = 1'b1;
    end
    grant_id     = gid_q;
    grant_valid  = (state_q != IDLE);
    grant_hp     = hp_q;
    hold_timeout = to_q;
  end

endmodule
